// File: rtl/rsa_word_sequencer.sv
// rsa_word_sequencer
//   Packs a byte stream (MSB first) into 32-bit words. It hands each word to an
//   external modular exponentiator, then streams the 32-bit result back out as
//   bytes (MSB first). Only one word is in flight at a time.
//
// Optional feature: define RSA_SEQ_TIMEOUT_EN to abort a WAIT that lasts
//   TIMEOUT_CYCLES cycles. The abort pulses err_timeout and fme_rst.
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   key_load, key_e, key_n        key capture (only when idle between words)
//   in_valid/in_data/in_ready     byte input handshake
//   out_valid/out_data/out_ready  byte output handshake
//   fme_start, fme_base, fme_exponent, fme_modulo   exponentiator request
//   fme_result, fme_done          exponentiator response
//   fme_rst                       exponentiator abort/reset
//   err_range                     pulse: word >= modulus, word dropped
//   err_timeout                   pulse: exponentiator timed out
//   key_valid                     keys loaded and key_n >= 2
module rsa_word_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_load,
    input  logic [31:0] key_e,
    input  logic [31:0] key_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        fme_start,
    output logic [31:0] fme_base,
    output logic [31:0] fme_exponent,
    output logic [31:0] fme_modulo,
    input  logic [31:0] fme_result,
    input  logic        fme_done,
    output logic        fme_rst,
    output logic        err_range,
    output logic        err_timeout,
    output logic        key_valid
);

    typedef enum logic [1:0] {COLLECT, START, WAIT, EMIT} state_t;

    state_t      state_q;
    logic [1:0]  cnt_q;        // byte index: input bytes in COLLECT, output bytes in EMIT
    logic [31:0] word_q;
    logic [31:0] res_q;
    logic [31:0] key_e_q;
    logic [31:0] key_n_q;
    logic        key_valid_q;
    logic        out_of_range;
    logic        tmo_fire;

    assign out_of_range = (word_q >= key_n_q);

`ifdef RSA_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wait_cnt_q;
    logic          tmo_q;

    // Fire on the last allowed WAIT cycle. The pulse is registered, so it
    // appears in the first cycle back in COLLECT. A done pulse in the same
    // cycle takes priority.
    assign tmo_fire = (state_q == WAIT) && !fme_done &&
                      (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
            tmo_q      <= 1'b0;
        end else begin
            wait_cnt_q <= (state_q == WAIT) ? wait_cnt_q + TW'(1) : '0;
            tmo_q      <= tmo_fire;
        end
    end

    assign err_timeout = tmo_q & ~rst;
    assign fme_rst     = rst | tmo_q;
`else
    // The parameter has no effect unless the timeout is built in.
    logic unused_tmo;
    assign unused_tmo  = (TIMEOUT_CYCLES == 0);
    assign tmo_fire    = 1'b0;
    assign err_timeout = 1'b0;
    assign fme_rst     = rst;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            cnt_q       <= 2'd0;
            word_q      <= '0;
            res_q       <= '0;
            key_e_q     <= '0;
            key_n_q     <= '0;
            key_valid_q <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    // Keys may only change between words, so the operands
                    // stay stable for the whole exponentiation.
                    if (key_load && cnt_q == 2'd0) begin
                        key_e_q     <= key_e;
                        key_n_q     <= key_n;
                        key_valid_q <= (key_n >= 32'd2);
                    end
                    if (in_valid && in_ready) begin
                        word_q <= {word_q[23:0], in_data};
                        cnt_q  <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3)
                            state_q <= START;
                    end
                end
                START: begin
                    if (out_of_range) begin
                        word_q  <= '0;
                        state_q <= COLLECT;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (fme_done) begin
                        res_q   <= fme_result;
                        state_q <= EMIT;
                    end else if (tmo_fire) begin
                        word_q  <= '0;
                        state_q <= COLLECT;
                    end
                end
                EMIT: begin
                    // cnt_q is 0 on entry. It wraps back to 0 after 4 bytes,
                    // ready for the next input word.
                    if (out_ready) begin
                        res_q <= {res_q[23:0], 8'h00};
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3)
                            state_q <= COLLECT;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    // Outputs decode from registered state only.
    // Reset forces all outputs to 0 in the reset cycle itself.
    assign in_ready     = ~rst && (state_q == COLLECT) && key_valid_q;
    assign out_valid    = ~rst && (state_q == EMIT);
    assign out_data     = out_valid ? res_q[31:24] : 8'h00;
    assign fme_start    = ~rst && (state_q == START) && !out_of_range;
    assign err_range    = ~rst && (state_q == START) && out_of_range;
    assign fme_base     = rst ? 32'd0 : word_q;
    assign fme_exponent = rst ? 32'd0 : key_e_q;
    assign fme_modulo   = rst ? 32'd0 : key_n_q;
    assign key_valid    = ~rst && key_valid_q;

endmodule

// File: tb/tb_rsa_word_sequencer.sv
module tb_rsa_word_sequencer;

    logic        clk = 1'b0;
    logic        rst, key_load, in_valid, out_ready, fme_done;
    logic [31:0] key_e, key_n, fme_result;
    logic [7:0]  in_data;
    logic        in_ready, out_valid, fme_start, fme_rst, err_range, err_timeout, key_valid;
    logic [7:0]  out_data;
    logic [31:0] fme_base, fme_exponent, fme_modulo;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rsa_word_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .key_load(key_load), .key_e(key_e), .key_n(key_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .fme_start(fme_start), .fme_base(fme_base), .fme_exponent(fme_exponent),
        .fme_modulo(fme_modulo), .fme_result(fme_result), .fme_done(fme_done),
        .fme_rst(fme_rst), .err_range(err_range), .err_timeout(err_timeout),
        .key_valid(key_valid)
    );

    // Reference exponentiator: plain square-and-multiply.
    function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                           input logic [31:0] n);
        longint unsigned r, x, nn;
        nn = {32'd0, n};
        r  = 64'd1 % nn;
        x  = {32'd0, b} % nn;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * x) % nn;
            x = (x * x) % nn;
        end
        return r[31:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load_keys(input logic [31:0] e, input logic [31:0] n);
        key_load = 1'b1; key_e = e; key_n = n;
        step;
        key_load = 1'b0; key_e = $urandom; key_n = $urandom;
        chk("key_valid", key_valid, (n >= 32'd2));
        chk("in_ready_keys", in_ready, (n >= 32'd2));
    endtask

    // Sends 4 bytes. Returns at the sample point of the START cycle.
    task automatic send_bytes(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(w >> (24 - 8 * i));
            chk("in_ready", in_ready, 1);
            step;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // mode: 0 = random out_ready, 1 = always ready, 2 = 5-cycle stall after first byte
    task automatic do_word(input logic [31:0] w, input logic [31:0] e, input logic [31:0] n,
                           input bit rng, input logic [31:0] expres, input int mode,
                           input bit kl_wait);
        int dly, acc, budget, stall;
        bit held, rdy;
        logic [7:0] held_data;
        send_bytes(w);
        chk("err_range", err_range, rng);
        chk("fme_start", fme_start, !rng);
        if (rng) begin
            step;
            chk("err_range_pulse", err_range, 0);
            chk("fme_start_range", fme_start, 0);
            chk("in_ready_after_range", in_ready, 1);
            return;
        end
        chk("fme_base", fme_base, w);
        chk("fme_exponent", fme_exponent, e);
        chk("fme_modulo", fme_modulo, n);
        step;
        chk("fme_start_pulse", fme_start, 0);
        chk("in_ready_wait", in_ready, 0);
        dly = kl_wait ? 3 : $urandom_range(0, 5);
        for (int d = 0; d < dly; d++) begin
            if (kl_wait && d == 0) begin
                key_load = 1'b1; key_e = ~e; key_n = 32'd7;
            end
            step;
            key_load = 1'b0;
        end
        chk("fme_base_hold", fme_base, w);
        chk("fme_exponent_hold", fme_exponent, e);
        chk("fme_modulo_hold", fme_modulo, n);
        chk("out_valid_wait", out_valid, 0);
        fme_result = modexp(fme_base, fme_exponent, fme_modulo);
        fme_done   = 1'b1;
        step;
        fme_done   = 1'b0;
        fme_result = $urandom;
        acc = 0; budget = 0; stall = 0; held = 1'b0; held_data = 8'h00;
        while (acc < 4 && budget < 100) begin
            chk("out_valid", out_valid, 1);
            if (!out_valid) break;
            if (held) chk("out_hold", out_data, held_data);
            case (mode)
                1:       rdy = 1'b1;
                2:       rdy = !(acc == 1 && stall < 5);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (!rdy) stall++;
            out_ready = rdy;
            if (rdy) begin
                chk($sformatf("out_byte%0d", acc), out_data, 8'(expres >> (24 - 8 * acc)));
                acc++;
                held = 1'b0;
            end else begin
                held = 1'b1;
                held_data = out_data;
            end
            step;
            budget++;
        end
        out_ready = 1'b0;
        chk("emit_count", acc, 4);
        if (mode == 2) chk("stall_cycles", stall, 5);
        chk("out_valid_done", out_valid, 0);
        chk("in_ready_after_emit", in_ready, 1);
    endtask

    typedef struct {
        logic [31:0] e;
        logic [31:0] n;
        logic [31:0] w;
        bit          rng;
        logic [31:0] res;
    } vec_t;

    initial begin
        vec_t tv[11];
        logic [31:0] re, rn, rw;

        tv[0]  = '{32'd17, 32'd3233, 32'h41, 1'b0, 32'd2790};
        tv[1]  = '{32'd17, 32'd3233, 32'd3233, 1'b1, 32'd0};
        tv[2]  = '{32'd17, 32'd3233, 32'd3232, 1'b0, 32'd3232};
        tv[3]  = '{32'd3, 32'd33, 32'd4, 1'b0, 32'd31};
        tv[4]  = '{32'd3, 32'd33, 32'd33, 1'b1, 32'd0};
        tv[5]  = '{32'd7, 32'd33, 32'd0, 1'b0, 32'd0};
        tv[6]  = '{32'd1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0, 32'h1234_5678};
        tv[7]  = '{32'd5, 32'd2, 32'd1, 1'b0, 32'd1};
        tv[8]  = '{32'd5, 32'd2, 32'd2, 1'b1, 32'd0};
        tv[9]  = '{32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd0};
        tv[10] = '{32'd0, 32'd33, 32'd5, 1'b0, 32'd1};

        rst = 1'b1; key_load = 1'b0; key_e = '0; key_n = '0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0; fme_done = 1'b0; fme_result = '0;

        // Reset state
        step;
        chk("rst_fme_rst", fme_rst, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fme_start", fme_start, 0);
        chk("rst_err_range", err_range, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_fme_base", fme_base, 0);
        rst = 1'b0;
        step;
        chk("fme_rst_release", fme_rst, 0);
        chk("in_ready_nokey", in_ready, 0);

        // key_n = 1 is not a usable modulus
        load_keys(32'd17, 32'd1);

        // Table vectors
        foreach (tv[i]) begin
            load_keys(tv[i].e, tv[i].n);
            do_word(tv[i].w, tv[i].e, tv[i].n, tv[i].rng, tv[i].res, 1, 1'b0);
        end

        // Output stall mid-EMIT
        load_keys(32'd17, 32'd3233);
        do_word(32'h41, 32'd17, 32'd3233, 1'b0, 32'd2790, 2, 1'b0);

        // key_load during WAIT is ignored; the next word still uses the old keys
        do_word(32'h41, 32'd17, 32'd3233, 1'b0, 32'd2790, 1, 1'b1);
        do_word(32'd3232, 32'd17, 32'd3233, 1'b0, 32'd3232, 1, 1'b0);

        // fme_done while idle is ignored
        fme_done = 1'b1; fme_result = 32'hDEAD_BEEF;
        step;
        fme_done = 1'b0;
        chk("stray_done_out_valid", out_valid, 0);
        chk("stray_done_in_ready", in_ready, 1);

`ifdef RSA_SEQ_TIMEOUT_EN
        send_bytes(32'h41);
        chk("tmo_fme_start", fme_start, 1);
        for (int c = 0; c < 16; c++) begin
            step;
            chk("tmo_early", err_timeout, 0);
            chk("tmo_early_fme_rst", fme_rst, 0);
        end
        step;
        chk("tmo_pulse", err_timeout, 1);
        chk("tmo_fme_rst", fme_rst, 1);
        chk("tmo_in_ready", in_ready, 1);
        fme_done = 1'b1;
        step;
        fme_done = 1'b0;
        chk("tmo_pulse_end", err_timeout, 0);
        chk("tmo_fme_rst_end", fme_rst, 0);
        chk("tmo_late_done", out_valid, 0);
`else
        send_bytes(32'h41);
        chk("notmo_fme_start", fme_start, 1);
        for (int c = 0; c < 40; c++) begin
            step;
            chk("notmo_err_timeout", err_timeout, 0);
            chk("notmo_fme_rst", fme_rst, 0);
        end
        fme_done = 1'b1; fme_result = 32'h0000_0AE6;
        step;
        fme_done = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            chk("notmo_out_valid", out_valid, 1);
            step;
        end
        out_ready = 1'b0;
        chk("notmo_in_ready", in_ready, 1);
`endif

        // Reset during WAIT
        send_bytes(32'h41);
        step;
        chk("wait_before_rst", in_ready, 0);
        rst = 1'b1;
        step;
        chk("rst_wait_fme_rst", fme_rst, 1);
        chk("rst_wait_out_valid", out_valid, 0);
        chk("rst_wait_key_valid", key_valid, 0);
        chk("rst_wait_fme_modulo", fme_modulo, 0);
        rst = 1'b0;
        fme_done = 1'b1; fme_result = 32'd2790;
        step;
        fme_done = 1'b0;
        chk("post_rst_done_ignored", out_valid, 0);
        chk("post_rst_key_valid", key_valid, 0);
        chk("post_rst_in_ready", in_ready, 0);
        step;
        chk("post_rst_out_valid2", out_valid, 0);

        // Random words against the reference model
        for (int k = 0; k < 30; k++) begin
            re = $urandom;
            rn = $urandom;
            if (rn < 32'd2) rn = 32'd2;
            rw = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom) % rn;
            load_keys(re, rn);
            do_word(rw, re, rn, (rw >= rn), modexp(rw, re, rn), 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
